// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor
// Drives the active-high reset of the ADC-clock DCM and watches its lock
// indication. It pulses reset on start-up, on loss of lock and on software
// request, retries a bounded number of times and then reports a sticky failure.
// Optional build macro DCM_LOCKLOSS_COUNTER_EN enables the 16-bit lock-loss
// event counter; without it lockloss_count_o is tied to zero.
module dcm_lock_supervisor #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        force_reset_i,
  input  logic        locked_i,
  output logic        dcm_reset_o,
  output logic        locked_stable_o,
  output logic        fail_o,
  output logic [3:0]  retry_count_o,
  output logic [2:0]  state_o,
  output logic [15:0] lockloss_count_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_LOCKED    = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  logic             lk_p0;
  logic             lk_p1;
  logic             lk_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       retry_q;
  logic [3:0]       retry_d;
  logic             attempt_fail;
  logic             lockloss_evt;
  logic             lockloss_clr;
  logic             dcm_reset_q;
  logic             stable_q;
  logic             fail_q;

  // Two-flop synchronizer bringing the asynchronous lock flag into clk_i
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lk_p0 <= 1'b0;
      lk_p1 <= 1'b0;
    end else begin
      lk_p0 <= locked_i;
      lk_p1 <= lk_p0;
    end
  end

  assign lk_s = lk_p1;

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      dcm_reset_q <= 1'b1;
      stable_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_reset_q <= (state_d == S_IDLE) || (state_d == S_RESET);
      stable_q    <= (state_d == S_LOCKED);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  // Next-state logic: enable beats force_reset, which beats normal sequencing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    lockloss_evt = 1'b0;
    lockloss_clr = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else if (force_reset_i) begin
      state_d      = S_RESET;
      cnt_d        = '0;
      retry_d      = 4'd0;
      lockloss_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RESET;
          cnt_d   = '0;
          retry_d = 4'd0;
        end
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_LOCKED;
            cnt_d   = '0;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_LOCKED: begin
          if (!lk_s) begin
            state_d      = S_RESET;
            cnt_d        = '0;
            retry_d      = 4'd0;
            lockloss_evt = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          retry_d = 4'd0;
        end
      endcase
      if (attempt_fail) begin
        cnt_d = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = S_RESET;
        end else begin
          state_d = S_FAIL;
        end
      end
    end
  end

`ifdef DCM_LOCKLOSS_COUNTER_EN
  logic [15:0] lockloss_q;

  // Saturating count of lock-loss events seen while LOCKED
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lockloss_q <= 16'd0;
    end else if (lockloss_clr) begin
      lockloss_q <= 16'd0;
    end else if (lockloss_evt && (lockloss_q != 16'hFFFF)) begin
      lockloss_q <= lockloss_q + 16'd1;
    end
  end

  assign lockloss_count_o = lockloss_q;
`else
  logic lockloss_unused;
  assign lockloss_unused  = lockloss_evt ^ lockloss_clr;
  assign lockloss_count_o = 16'd0;
`endif

  assign dcm_reset_o     = dcm_reset_q;
  assign locked_stable_o = stable_q;
  assign fail_o          = fail_q;
  assign retry_count_o   = retry_q;
  assign state_o         = state_q;

endmodule
